// File: rtl/dmem_port_arbiter.sv
// Shares the core's single data-memory port between the speculative load unit
// and the store commit path, one outstanding request at a time.
module dmem_port_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic [31:0]      ld_resp_rdata,

  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_wmask,
  input  logic [31:0]      st_wdata,
  output logic             st_done,

  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LD,
    ISSUE_ST,
    WAIT_LD,
    WAIT_ST,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         rmask_q, rmask_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               ld_pulse_q, ld_pulse_d;
  logic               st_done_q, st_done_d;

  logic               is_idle;
  logic               st_accept;
  logic               ld_accept;

  // rst is folded in so neither requester sees a handshake while held in reset.
  assign is_idle   = rst & (state_q == IDLE);
  assign st_accept = is_idle & st_req_valid;
  assign ld_accept = is_idle & ld_req_valid & ~st_req_valid & ~flush;

  assign st_req_ready = st_accept;
  assign ld_req_ready = ld_accept;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rmask_d      = rmask_q;
    wmask_d      = wmask_q;
    tag_d        = tag_q;
    resp_tag_d   = resp_tag_q;
    resp_rdata_d = resp_rdata_q;
    ld_pulse_d   = 1'b0;
    st_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (st_accept) begin
          addr_d  = st_addr;
          wdata_d = st_wdata;
          wmask_d = st_wmask;
          rmask_d = 4'h0;
          state_d = ISSUE_ST;
        end else if (ld_accept) begin
          addr_d  = ld_addr;
          rmask_d = ld_rmask;
          wmask_d = 4'h0;
          tag_d   = ld_tag;
          state_d = ISSUE_LD;
        end
      end

      ISSUE_LD: begin
        rmask_d = 4'h0;
        wmask_d = 4'h0;
        state_d = flush ? DRAIN : WAIT_LD;
      end

      ISSUE_ST: begin
        rmask_d = 4'h0;
        wmask_d = 4'h0;
        state_d = WAIT_ST;
      end

      WAIT_LD: begin
        // A flush landing with the response still kills the load outright.
        if (dmem_resp) begin
          state_d = IDLE;
          if (!flush) begin
            ld_pulse_d   = 1'b1;
            resp_rdata_d = dmem_rdata;
            resp_tag_d   = tag_q;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      WAIT_ST: begin
        if (dmem_resp) begin
          st_done_d = 1'b1;
          state_d   = IDLE;
        end
      end

      DRAIN: begin
        if (dmem_resp) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rmask_q      <= 4'h0;
      wmask_q      <= 4'h0;
      tag_q        <= '0;
      resp_tag_q   <= '0;
      resp_rdata_q <= 32'h0;
      ld_pulse_q   <= 1'b0;
      st_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rmask_q      <= rmask_d;
      wmask_q      <= wmask_d;
      tag_q        <= tag_d;
      resp_tag_q   <= resp_tag_d;
      resp_rdata_q <= resp_rdata_d;
      ld_pulse_q   <= ld_pulse_d;
      st_done_q    <= st_done_d;
    end
  end

  // The load pulse is gated combinationally so a same-cycle flush still hides it.
  assign ld_resp_valid = ld_pulse_q & ~flush;
  assign ld_resp_tag   = resp_tag_q;
  assign ld_resp_rdata = resp_rdata_q;
  assign st_done       = st_done_q;

  assign dmem_addr  = addr_q;
  assign dmem_rmask = rmask_q;
  assign dmem_wmask = wmask_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_dmem_port_arbiter;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rstN;
  logic             flush;
  logic             ldReqValid;
  logic             ldReqReady;
  logic [31:0]      ldAddr;
  logic [3:0]       ldRmask;
  logic [TAG_W-1:0] ldTag;
  logic             ldRespValid;
  logic [TAG_W-1:0] ldRespTag;
  logic [31:0]      ldRespRdata;
  logic             stReqValid;
  logic             stReqReady;
  logic [31:0]      stAddr;
  logic [3:0]       stWmask;
  logic [31:0]      stWdata;
  logic             stDone;
  logic [31:0]      dmemAddr;
  logic [3:0]       dmemRmask;
  logic [3:0]       dmemWmask;
  logic [31:0]      dmemWdata;
  logic [31:0]      dmemRdata;
  logic             dmemResp;

  int checkCount = 0;
  int failCount  = 0;

  dmem_port_arbiter #(.TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rstN),
    .flush         (flush),
    .ld_req_valid  (ldReqValid),
    .ld_req_ready  (ldReqReady),
    .ld_addr       (ldAddr),
    .ld_rmask      (ldRmask),
    .ld_tag        (ldTag),
    .ld_resp_valid (ldRespValid),
    .ld_resp_tag   (ldRespTag),
    .ld_resp_rdata (ldRespRdata),
    .st_req_valid  (stReqValid),
    .st_req_ready  (stReqReady),
    .st_addr       (stAddr),
    .st_wmask      (stWmask),
    .st_wdata      (stWdata),
    .st_done       (stDone),
    .dmem_addr     (dmemAddr),
    .dmem_rmask    (dmemRmask),
    .dmem_wmask    (dmemWmask),
    .dmem_wdata    (dmemWdata),
    .dmem_rdata    (dmemRdata),
    .dmem_resp     (dmemResp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             sv;
    logic [31:0]      sa;
    logic [3:0]       swm;
    logic [31:0]      swd;
    logic             lv;
    logic [31:0]      la;
    logic [3:0]       lrm;
    logic [TAG_W-1:0] lt;
    logic             fl;
    logic             rs;
    logic [31:0]      rd;
  } stim_t;

  // Reference model: one outstanding transaction described by its kind, its age in
  // cycles since acceptance (1 = the issue cycle) and whether a flush has killed it.
  logic             mBusy, mIsStore, mKilled, mPendLd, mPendSt;
  int               mAge;
  logic [31:0]      mAddr, mWdata, mRespData;
  logic [3:0]       mRmask, mWmask;
  logic [TAG_W-1:0] mTag, mRespTag;

  task automatic modelReset();
    mBusy = 0; mIsStore = 1; mKilled = 0; mPendLd = 0; mPendSt = 0; mAge = 0;
    mAddr = 0; mWdata = 0; mRespData = 0; mRmask = 0; mWmask = 0; mTag = 0; mRespTag = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", name, observed, expected, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.sv = 0; s.sa = 0; s.swm = 0; s.swd = 0;
    s.lv = 0; s.la = 0; s.lrm = 0; s.lt = 0;
    s.fl = 0; s.rs = 0; s.rd = 0;
    return s;
  endfunction

  // Drives one cycle of inputs after the falling edge, checks every output against
  // the model, then advances the model to what the next rising edge should produce.
  task automatic applyStimulus(input stim_t s);
    logic eStReady, eLdReady;
    logic [3:0] eRm, eWm;
    @(negedge clk);
    stReqValid = s.sv; stAddr = s.sa; stWmask = s.swm; stWdata = s.swd;
    ldReqValid = s.lv; ldAddr = s.la; ldRmask = s.lrm; ldTag = s.lt;
    flush = s.fl; dmemResp = s.rs; dmemRdata = s.rd;
    #1;
    eStReady = !mBusy && s.sv;
    eLdReady = !mBusy && s.lv && !s.sv && !s.fl;
    eRm = (mBusy && mAge == 1 && !mIsStore) ? mRmask : 4'h0;
    eWm = (mBusy && mAge == 1 &&  mIsStore) ? mWmask : 4'h0;
    checkOutput("st_req_ready", stReqReady, eStReady);
    checkOutput("ld_req_ready", ldReqReady, eLdReady);
    checkOutput("dmem_rmask", dmemRmask, eRm);
    checkOutput("dmem_wmask", dmemWmask, eWm);
    checkOutput("dmem_addr", dmemAddr, mAddr);
    if (mIsStore) checkOutput("dmem_wdata", dmemWdata, mWdata);
    checkOutput("ld_resp_valid", ldRespValid, mPendLd && !s.fl);
    checkOutput("ld_resp_tag", ldRespTag, mRespTag);
    checkOutput("ld_resp_rdata", ldRespRdata, mRespData);
    checkOutput("st_done", stDone, mPendSt);

    mPendLd = 0;
    mPendSt = 0;
    if (mBusy) begin
      if (!mIsStore && s.fl) mKilled = 1;
      if (mAge >= 2 && s.rs) begin
        mBusy = 0;
        if (mIsStore) mPendSt = 1;
        else if (!mKilled) begin
          mPendLd = 1; mRespTag = mTag; mRespData = s.rd;
        end
      end
      mAge++;
    end else if (eStReady) begin
      mBusy = 1; mIsStore = 1; mAge = 1;
      mAddr = s.sa; mWmask = s.swm; mRmask = 0; mWdata = s.swd;
    end else if (eLdReady) begin
      mBusy = 1; mIsStore = 0; mAge = 1; mKilled = 0;
      mAddr = s.la; mRmask = s.lrm; mWmask = 0; mTag = s.lt;
    end
  endtask

  task automatic runUntilIdle();
    stim_t s;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      s = idleStim();
      s.rs = mBusy && mAge >= 2;
      s.rd = $urandom;
      applyStimulus(s);
      done = !mBusy && !mPendLd && !mPendSt;
    end
    if (!done) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL idle_timeout: observed busy expected idle within 20 cycles");
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    stReqValid = 1; ldReqValid = 1; flush = 0; dmemResp = 0;
    rstN = 0;
    #1;
    modelReset();
    checkOutput("rst_st_req_ready", stReqReady, 0);
    checkOutput("rst_ld_req_ready", ldReqReady, 0);
    checkOutput("rst_ld_resp_valid", ldRespValid, 0);
    checkOutput("rst_st_done", stDone, 0);
    checkOutput("rst_dmem_addr", dmemAddr, 0);
    checkOutput("rst_dmem_rmask", dmemRmask, 0);
    checkOutput("rst_dmem_wmask", dmemWmask, 0);
    checkOutput("rst_dmem_wdata", dmemWdata, 0);
    checkOutput("rst_ld_resp_tag", ldRespTag, 0);
    checkOutput("rst_ld_resp_rdata", ldRespRdata, 0);
    @(negedge clk);
    stReqValid = 0; ldReqValid = 0;
    rstN = 1;
  endtask

  function automatic stim_t loadStim(input logic [31:0] a, input logic [3:0] m, input logic [TAG_W-1:0] t);
    stim_t s = idleStim();
    s.lv = 1; s.la = a; s.lrm = m; s.lt = t;
    return s;
  endfunction

  function automatic stim_t storeStim(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    stim_t s = idleStim();
    s.sv = 1; s.sa = a; s.swm = m; s.swd = d;
    return s;
  endfunction

  initial begin
    stim_t s;
    stReqValid = 0; stAddr = 0; stWmask = 0; stWdata = 0;
    ldReqValid = 0; ldAddr = 0; ldRmask = 0; ldTag = 0;
    flush = 0; dmemResp = 0; dmemRdata = 0;
    rstN = 1;
    modelReset();
    applyReset();

    // Single uncontended load, memory answering two cycles after the issue cycle.
    applyStimulus(loadStim(32'h1000, 4'hF, 5'd3));
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    s = idleStim(); s.rs = 1; s.rd = 32'hDEADBEEF;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("single_ld_valid", ldRespValid, 1);
    checkOutput("single_ld_tag", ldRespTag, 3);
    checkOutput("single_ld_rdata", ldRespRdata, 32'hDEADBEEF);

    // Store and load together: store wins, load is taken when the FSM returns to IDLE.
    s = storeStim(32'h2004, 4'h3, 32'h0000ABCD);
    s.lv = 1; s.la = 32'h2100; s.lrm = 4'hC; s.lt = 5'd9;
    applyStimulus(s);
    s = loadStim(32'h2100, 4'hC, 5'd9);
    applyStimulus(s);
    s.rs = 1;
    applyStimulus(s);
    s.rs = 0;
    applyStimulus(s);
    checkOutput("simul_st_done", stDone, 1);
    checkOutput("simul_ld_taken", ldReqReady, 1);
    runUntilIdle();

    // Flush one cycle before the response while waiting on a load.
    applyStimulus(loadStim(32'h1400, 4'h1, 5'd7));
    applyStimulus(idleStim());
    s = loadStim(32'h1800, 4'h2, 5'd8); s.fl = 1;
    applyStimulus(s);
    s.fl = 0;
    applyStimulus(s);
    checkOutput("drain_ld_blocked", ldReqReady, 0);
    s.rs = 1; s.rd = 32'h12345678;
    applyStimulus(s);
    s.rs = 0; s.lv = 0;
    applyStimulus(s);
    checkOutput("drain_no_pulse", ldRespValid, 0);

    // Flush has no effect on a store in flight.
    applyStimulus(storeStim(32'h3000, 4'hF, 32'hCAFEF00D));
    applyStimulus(idleStim());
    s = idleStim(); s.fl = 1;
    applyStimulus(s);
    s.rs = 1;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("flush_st_done", stDone, 1);

    // Flush coincident with the response pulse cycle.
    applyStimulus(loadStim(32'h4000, 4'hF, 5'd11));
    applyStimulus(idleStim());
    s = idleStim(); s.rs = 1; s.rd = 32'hA5A5A5A5;
    applyStimulus(s);
    s = idleStim(); s.fl = 1;
    applyStimulus(s);
    checkOutput("pulse_flush_hidden", ldRespValid, 0);
    applyStimulus(loadStim(32'h4004, 4'h8, 5'd12));

    // Flush coincident with the memory response in WAIT_LD.
    applyStimulus(idleStim());
    s = idleStim(); s.fl = 1; s.rs = 1; s.rd = 32'h5A5A5A5A;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("resp_flush_hidden", ldRespValid, 0);

    // Reset mid-WAIT_LD, then a stray response and a fresh load.
    applyStimulus(loadStim(32'h5000, 4'hF, 5'd13));
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    applyReset();
    s = idleStim(); s.rs = 1; s.rd = 32'hBADBAD00;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("stray_no_pulse", ldRespValid, 0);
    applyStimulus(loadStim(32'h6000, 4'h6, 5'd21));
    applyStimulus(idleStim());
    s = idleStim(); s.rs = 1; s.rd = 32'h600DDA7A;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("post_rst_tag", ldRespTag, 21);
    checkOutput("post_rst_rdata", ldRespRdata, 32'h600DDA7A);

    // Random mixed traffic with random flushes and memory latency.
    for (int i = 0; i < 400; i++) begin
      s.sv  = ($urandom % 4) == 0;
      s.sa  = $urandom & 32'hFFFF_FFFC;
      s.swm = 4'($urandom_range(1, 15));
      s.swd = $urandom;
      s.lv  = ($urandom % 3) == 0;
      s.la  = $urandom & 32'hFFFF_FFFC;
      s.lrm = 4'($urandom_range(1, 15));
      s.lt  = TAG_W'($urandom);
      s.fl  = ($urandom % 8) == 0;
      s.rd  = $urandom;
      if (mBusy && mAge >= 2) s.rs = ($urandom % 3) == 0;
      else if (mBusy)         s.rs = 0;
      else                    s.rs = ($urandom % 16) == 0;
      applyStimulus(s);
    end
    runUntilIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Owns the single data-memory port of the OoO core and shares it between two requesters.
- Requester 1: the load unit, which issues speculative loads.
- Requester 2: the store commit path, which issues stores retired at the ROB head.
- One request is outstanding at a time. The block registers the request, drives a one-cycle request pulse on the dmem port, waits for dmem_resp, returns the result, and discards responses to loads killed by flush.

Parameters:
- TAG_W, 5, width of the ROB tag carried with each load.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low (block is in reset while rst==0)
- flush  in  1  pipeline flush; kills in-flight and pending loads
- ld_req_valid  in  1  load request valid
- ld_req_ready  out  1  load request accepted this cycle
- ld_addr  in  32  load address (word-aligned)
- ld_rmask  in  4  load byte mask, nonzero
- ld_tag  in  TAG_W  ROB tag of the load
- ld_resp_valid  out  1  load data valid (one-cycle pulse)
- ld_resp_tag  out  TAG_W  tag of the returned load
- ld_resp_rdata  out  32  raw dmem word
- st_req_valid  in  1  committed store valid
- st_req_ready  out  1  store request accepted this cycle
- st_addr  in  32  store address (word-aligned)
- st_wmask  in  4  store byte mask, nonzero
- st_wdata  in  32  store data, already lane-aligned
- st_done  out  1  store completed (one-cycle pulse)
- dmem_addr  out  32  memory address
- dmem_rmask  out  4  memory read mask
- dmem_wmask  out  4  memory write mask
- dmem_wdata  out  32  memory write data
- dmem_rdata  in  32  memory read data
- dmem_resp  in  1  memory response, one cycle

Behaviour:
- FSM states: IDLE, ISSUE_LD, ISSUE_ST, WAIT_LD, WAIT_ST, DRAIN. All state and outputs are registered except the two ready signals and the flush gating of ld_resp_valid.
- Reset (rst==0, asynchronous):
  - State goes to IDLE.
  - dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, ld_resp_tag, ld_resp_rdata all = 0.
  - ld_resp_valid = 0, st_done = 0.
  - ld_req_ready = 0 and st_req_ready = 0 while in reset.
  - Reset mid-transaction abandons the transaction. Any later dmem_resp is ignored because it arrives in IDLE.
- Readiness:
  - st_req_ready = (state==IDLE) & st_req_valid.
  - ld_req_ready = (state==IDLE) & ld_req_valid & ~st_req_valid & ~flush.
  - The store has strict priority. A load is never accepted in a flush cycle.
- Accept at edge N:
  - The request fields are latched into the dmem_* registers.
  - Store: dmem_wmask=st_wmask, dmem_rmask=0.
  - Load: dmem_rmask=ld_rmask, dmem_wmask=0, and ld_tag is held internally.
  - State moves to ISSUE_ST or ISSUE_LD.
- ISSUE (exactly one cycle, N+1):
  - Masks are nonzero for this cycle only.
  - The next state is WAIT_ST or WAIT_LD, or DRAIN for a load if flush is high in this cycle.
  - Masks return to 0. dmem_addr and dmem_wdata hold their values until the next accept.
- dmem_resp is sampled only in WAIT_LD, WAIT_ST and DRAIN. It is ignored in all other states; memory never responds in the ISSUE cycle.
- WAIT_LD:
  - flush with no dmem_resp: go to DRAIN.
  - dmem_resp in cycle R: capture dmem_rdata and the tag, pulse ld_resp_valid in cycle R+1, go to IDLE (ready may rise in R+1).
  - flush and dmem_resp in the same cycle: the response is discarded, no pulse, go to IDLE.
- ld_resp_valid output = registered pulse & ~flush. A flush coinciding with the pulse cycle suppresses it. ld_resp_tag and ld_resp_rdata keep their captured value.
- WAIT_ST:
  - dmem_resp in cycle R pulses st_done in R+1 and returns to IDLE.
  - flush has no effect on stores in any state.
- DRAIN: wait for dmem_resp, drop the data with no pulse, return to IDLE.
- Minimum occupancy: accept N, issue N+1, resp at N+2 or later, IDLE at R+1. Back-to-back throughput is one request per 3 cycles.

Test Plan:
- Single load, no contention:
  - Stimulus: ld_addr=0x1000, rmask=0xF, tag=3; memory returns 0xDEADBEEF two cycles after the issue cycle.
  - Required: dmem_rmask=0xF for exactly 1 cycle; ld_resp_valid pulses with tag 3, rdata 0xDEADBEEF; dmem_wmask stays 0.
- Simultaneous requests:
  - Stimulus: store addr=0x2004, wmask=0x3, wdata=0x0000ABCD, and a load, both valid in the same IDLE cycle.
  - Required: the store is issued first and st_done pulses; the load is accepted on the cycle the FSM returns to IDLE and completes next.
- Flush during WAIT_LD:
  - Stimulus: load tag 7, flush asserted one cycle before dmem_resp.
  - Required: no ld_resp_valid pulse; ld_req_ready stays low until dmem_resp is consumed in DRAIN.
- Flush during WAIT_ST:
  - Stimulus: store addr=0x3000, flush asserted before dmem_resp.
  - Required: st_done still pulses; the store is not dropped.
- Flush coincident with the ld_resp_valid pulse cycle, and separately flush coincident with dmem_resp in WAIT_LD.
  - Required: no visible response in either case; FSM is in IDLE afterwards.
- Async reset (rst=0) asserted mid-WAIT_LD, then a stray dmem_resp after release.
  - Required: all outputs go to 0 immediately; the stray response produces no pulse; the first new load completes normally.
